controle_rega: RTL and testbench

CONTROLE_REGA -- requirements
Module: controle_rega

---
 rtl/controle_rega.sv | 169 ++++++++++++++++
 tb/tb_controle_rega.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/controle_rega.sv
// Irrigation controller: synchronized, debounced sensors feed a four-state FSM
// (idle, sprinkler, drip, latched alarm) with a minimum-run hold and a startup hold.
module controle_rega #(
   parameter int DEBOUNCE = 4,
   parameter int MIN_RUN  = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic HS,
   input  logic TA,
   input  logic NB,
   input  logic NA,
   input  logic alarm_ack,
   output logic AS,
   output logic US,
   output logic GT,
   output logic alarm_wire
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ASP  = 2'd1;
   localparam logic [1:0] S_GOT  = 2'd2;
   localparam logic [1:0] S_ALM  = 2'd3;

   localparam logic [7:0] DEB_LAST   = 8'(DEBOUNCE - 1);
   localparam logic [7:0] RUN_LAST   = 8'(MIN_RUN - 1);
   localparam logic [8:0] START_LAST = 9'(DEBOUNCE + 2);

   // Sensor bit order: 0 = HS, 1 = TA, 2 = NB, 3 = NA
   logic [3:0] sens_raw;
   logic [3:0] sync1_q;
   logic [3:0] sync2_q;
   logic [3:0] filt;

   assign sens_raw = {NA, NB, TA, HS};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= sens_raw;
         sync2_q <= sync1_q;
      end
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_deb
         logic [7:0] cnt_q;
         logic [7:0] cnt_d;
         logic       flt_q;
         logic       flt_d;

         always_comb begin
            flt_d = flt_q;
            cnt_d = cnt_q + 8'd1;
            if (sync2_q[gi] == flt_q) begin
               cnt_d = '0;
            end else if (cnt_q == DEB_LAST) begin
               flt_d = sync2_q[gi];
               cnt_d = '0;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt_q <= '0;
               flt_q <= 1'b0;
            end else begin
               cnt_q <= cnt_d;
               flt_q <= flt_d;
            end
         end

         assign filt[gi] = flt_q;
      end
   endgenerate

   logic hs_f;
   logic ta_f;
   logic nb_f;
   logic na_f;
   logic fault;

   assign hs_f  = filt[0];
   assign ta_f  = filt[1];
   assign nb_f  = filt[2];
   assign na_f  = filt[3];
   assign fault = ~nb_f | (na_f & ~nb_f);

   // FSM is frozen until the synchronizers and filters have seen real sensor data.
   logic [8:0] start_q;
   logic [8:0] start_d;
   logic       ready;

   assign ready   = (start_q == START_LAST);
   assign start_d = ready ? start_q : start_q + 9'd1;

   logic [1:0] state_q;
   logic [1:0] state_d;
   logic [7:0] run_q;
   logic [7:0] run_d;
   logic [7:0] run_inc;
   logic       run_done;

   assign run_inc  = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
   assign run_done = (run_q >= RUN_LAST);

   always_comb begin
      state_d = state_q;
      run_d   = run_q;
      if (ready) begin
         case (state_q)
            S_IDLE: begin
               if (fault) begin
                  state_d = S_ALM;
               end else if (!hs_f && ta_f && na_f) begin
                  state_d = S_ASP;
                  run_d   = '0;
               end else if (!hs_f) begin
                  state_d = S_GOT;
                  run_d   = '0;
               end
            end
            S_ASP: begin
               run_d = run_inc;
               if (fault) begin
                  state_d = S_ALM;
               end else if (hs_f && run_done) begin
                  state_d = S_IDLE;
               end else if (!na_f) begin
                  state_d = S_GOT;
               end
            end
            S_GOT: begin
               run_d = run_inc;
               if (fault) begin
                  state_d = S_ALM;
               end else if (hs_f && run_done) begin
                  state_d = S_IDLE;
               end
            end
            default: begin
               if (alarm_ack && !fault) begin
                  state_d = S_IDLE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         run_q   <= '0;
         start_q <= '0;
      end else begin
         state_q <= state_d;
         run_q   <= run_d;
         start_q <= start_d;
      end
   end

   assign US         = (state_q == S_IDLE);
   assign AS         = (state_q == S_ASP);
   assign GT         = (state_q == S_GOT);
   assign alarm_wire = (state_q == S_ALM);

endmodule

// File: tb/tb_controle_rega.sv
// Directed bench for controle_rega: table of sensor steps with per-edge output
// expectations, plus hand-written glitch and asynchronous-reset sequences.
module tb_controle_rega;

   localparam logic [3:0] O_AS = 4'b1000;
   localparam logic [3:0] O_US = 4'b0100;
   localparam logic [3:0] O_GT = 4'b0010;
   localparam logic [3:0] O_AL = 4'b0001;

   typedef struct {
      logic       hs;
      logic       ta;
      logic       nb;
      logic       na;
      logic       ack;
      int         edges;
      logic [3:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   logic HS, TA, NB, NA, alarm_ack;
   logic AS, US, GT, alarm_wire;
   logic [3:0] outs;

   int n_checks = 0;
   int n_errors = 0;
   logic [3:0] prev_exp;
   vec_t vq[$];

   always #5 clk = ~clk;

   controle_rega #(.DEBOUNCE(4), .MIN_RUN(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .HS         (HS),
      .TA         (TA),
      .NB         (NB),
      .NA         (NA),
      .alarm_ack  (alarm_ack),
      .AS         (AS),
      .US         (US),
      .GT         (GT),
      .alarm_wire (alarm_wire)
   );

   assign outs = {AS, US, GT, alarm_wire};

   function automatic vec_t mk(logic hs, logic ta, logic nb, logic na, logic ack,
                               int edges, logic [3:0] exp);
      vec_t v;
      v.hs = hs; v.ta = ta; v.nb = nb; v.na = na; v.ack = ack;
      v.edges = edges; v.exp = exp;
      return v;
   endfunction

   task automatic check(input string nm, input logic [3:0] exp);
      n_checks++;
      if (outs !== exp) begin
         n_errors++;
         $display("FAIL %s: got {AS,US,GT,AL}=%b expected %b", nm, outs, exp);
      end
   endtask

   // Earlier edges must keep the previous outputs; the last edge shows the new ones.
   task automatic run_vec(input vec_t v, input string tag);
      HS = v.hs; TA = v.ta; NB = v.nb; NA = v.na; alarm_ack = v.ack;
      for (int e = 1; e <= v.edges; e++) begin
         @(posedge clk);
         #1;
         alarm_ack = 1'b0;
         if (e < v.edges) check($sformatf("%s_edge%0d", tag, e), prev_exp);
         else             check(tag, v.exp);
      end
      prev_exp = v.exp;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //            hs ta nb na ack edges exp
      vq.push_back(mk(1, 0, 1, 1, 0, 100, O_US)); // 0  idle held 100 cycles
      vq.push_back(mk(0, 1, 1, 1, 0,   7, O_AS)); // 1  sprinkler at edge 7
      vq.push_back(mk(0, 1, 1, 1, 0,   5, O_AS)); // 2  run count reaches 5
      vq.push_back(mk(1, 1, 1, 1, 0,  11, O_US)); // 3  exit once run count hits 15
      vq.push_back(mk(0, 1, 1, 1, 0,   7, O_AS)); // 4  sprinkler again
      vq.push_back(mk(0, 1, 1, 0, 0,   7, O_GT)); // 5  NA low -> drip
      vq.push_back(mk(0, 1, 1, 0, 0,   8, O_GT)); // 6  run count reaches 15
      vq.push_back(mk(1, 1, 1, 0, 0,   7, O_US)); // 7  moist -> idle
      vq.push_back(mk(0, 0, 1, 1, 0,   7, O_GT)); // 8  drip (TA low)
      vq.push_back(mk(0, 0, 1, 1, 0,   3, O_GT)); // 9  run count 3
      vq.push_back(mk(0, 0, 0, 1, 0,   7, O_AL)); // 10 reservoir empty -> alarm
      vq.push_back(mk(0, 0, 0, 1, 1,   3, O_AL)); // 11 ack while faulted ignored
      vq.push_back(mk(1, 0, 1, 1, 0,   7, O_AL)); // 12 fault clears, no ack -> latched
      vq.push_back(mk(1, 0, 1, 1, 1,   1, O_US)); // 13 ack -> idle next edge
      vq.push_back(mk(0, 1, 0, 1, 0,   7, O_AL)); // 14 fault and request together
      vq.push_back(mk(1, 0, 1, 1, 0,   7, O_AL)); // 15 still latched
      vq.push_back(mk(1, 0, 1, 1, 1,   1, O_US)); // 16 ack -> idle
      vq.push_back(mk(1, 0, 1, 1, 0,  10, O_US)); // 17 stays idle

      rst_n = 1'b0;
      HS = 1'b1; TA = 1'b0; NB = 1'b1; NA = 1'b1; alarm_ack = 1'b0;
      #1;
      check("reset_state_async", O_US);
      repeat (3) @(posedge clk);
      #1;
      check("reset_state_clocked", O_US);
      rst_n = 1'b1;
      prev_exp = O_US;

      foreach (vq[i]) run_vec(vq[i], $sformatf("vec%0d", i));

      // Three-cycle HS glitch from idle must be filtered out
      HS = 1'b0; TA = 1'b1;
      for (int e = 1; e <= 3; e++) begin
         @(posedge clk);
         #1;
         check($sformatf("glitch_low_edge%0d", e), O_US);
      end
      HS = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         @(posedge clk);
         #1;
         check($sformatf("glitch_after_edge%0d", e), O_US);
      end

      // Asynchronous reset while sprinkling, then startup hold after release
      run_vec(mk(0, 1, 1, 1, 0, 7, O_AS), "pre_reset_as");
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_us", O_US);
      @(posedge clk);
      #1;
      check("reset_held_us", O_US);
      rst_n = 1'b1;
      prev_exp = O_US;
      run_vec(mk(0, 1, 1, 1, 0, 7, O_AS), "post_reset_hold");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
